// File: rtl/slt_seq_unit.sv
// Multi-cycle set-less-than unit: forms x + ~y + 1 CHUNK bits per cycle on one chunk adder.
// Optional feature macro SLT_MINMAX_EN adds registered min_val/max_val outputs.
module slt_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             set,
    output logic             overflow,
    output logic             eq,
`ifdef SLT_MINMAX_EN
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and the result fields stay stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_ny;
    logic             r_signed;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_nz;
    logic             r_set;
    logic             r_ovf;
    logic             r_eq;
`ifdef SLT_MINMAX_EN
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
`endif

    int               w_base;
    logic [CHUNK-1:0] w_xc;
    logic [CHUNK-1:0] w_yc;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_c_msb;
    logic             w_ovf;
    logic             w_set;
    logic             w_eq;

    assign w_base = int'(r_idx) * CHUNK;
    assign w_xc   = r_x[w_base +: CHUNK];
    assign w_yc   = r_ny[w_base +: CHUNK];
    assign w_sum  = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_idx == IW'(NCHUNK - 1));
    // Carry into the top bit, recovered from the top sum bit and its two addend bits.
    assign w_c_msb = w_sum[CHUNK-1] ^ w_xc[CHUNK-1] ^ w_yc[CHUNK-1];
    assign w_ovf   = w_c_msb ^ w_sum[CHUNK];
    assign w_set   = r_signed ? (w_sum[CHUNK-1] ^ w_ovf) : ~w_sum[CHUNK];
    assign w_eq    = ~(r_nz | (|w_sum[CHUNK-1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        o_dbg_state = r_state;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_ny     <= '0;
            r_signed <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_nz     <= 1'b0;
            r_set    <= 1'b0;
            r_ovf    <= 1'b0;
            r_eq     <= 1'b0;
`ifdef SLT_MINMAX_EN
            r_y      <= '0;
            r_min    <= '0;
            r_max    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x      <= x;
                        r_ny     <= ~y;
                        r_signed <= is_signed;
                        r_carry  <= 1'b1;
                        r_idx    <= '0;
                        r_nz     <= 1'b0;
`ifdef SLT_MINMAX_EN
                        r_y      <= y;
`endif
                    end
                end
                S_RUN: begin
                    r_carry <= w_sum[CHUNK];
                    r_nz    <= r_nz | (|w_sum[CHUNK-1:0]);
                    // idx stops at the last chunk instead of wrapping.
                    if (!w_last) begin
                        r_idx <= r_idx + IW'(1);
                    end else begin
                        r_set <= w_set;
                        r_ovf <= w_ovf;
                        r_eq  <= w_eq;
`ifdef SLT_MINMAX_EN
                        r_min <= w_set ? r_x : r_y;
                        r_max <= w_set ? r_y : r_x;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign set      = r_set;
    assign overflow = r_ovf;
    assign eq       = r_eq;
`ifdef SLT_MINMAX_EN
    assign min_val  = r_min;
    assign max_val  = r_max;
`endif

endmodule

// File: tb/tb_slt_seq_unit.sv
// Bench for slt_seq_unit: three instances (CHUNK 4, 1, 32) share stimulus and are checked
// against an arithmetic reference model; SLT_MINMAX_EN also enables min/max checks.
module tb_slt_seq_unit;

    localparam int W = 32;
    localparam int CH[3] = '{4, 1, 32};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;

    logic [2:0]      ir_v;
    logic [2:0]      ov_v;
    logic [2:0]      set_v;
    logic [2:0]      of_v;
    logic [2:0]      eq_v;
    logic [2:0][1:0] dbg_v;
`ifdef SLT_MINMAX_EN
    logic [W-1:0] mn_v[3];
    logic [W-1:0] mx_v[3];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        slt_seq_unit #(.WIDTH(W), .CHUNK(CH[g])) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (ir_v[g]),
            .x           (x),
            .y           (y),
            .is_signed   (is_signed),
            .out_valid   (ov_v[g]),
            .out_ready   (out_ready),
            .set         (set_v[g]),
            .overflow    (of_v[g]),
            .eq          (eq_v[g]),
`ifdef SLT_MINMAX_EN
            .min_val     (mn_v[g]),
            .max_val     (mx_v[g]),
`endif
            .o_dbg_state (dbg_v[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sg);
        logic         es;
        logic         eo;
        logic         ee;
        logic [W-1:0] d;
        int           lat[3];
        int           n;
        d  = xv - yv;
        eo = (xv[W-1] != yv[W-1]) && (d[W-1] != xv[W-1]);
        es = sg ? ($signed(xv) < $signed(yv)) : (xv < yv);
        ee = (xv == yv);

        @(posedge clk); #1;
        check("ready_idle", ir_v, 3'b111);
        x = xv; y = yv; is_signed = sg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; is_signed = ~sg;
        check("ready_busy", ir_v, 3'b000);

        lat = '{-1, -1, -1};
        n = 0;
        while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
            for (int k = 0; k < 3; k++) if (ov_v[k] && lat[k] < 0) lat[k] = n;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("latency[%0d]", k), lat[k], W / CH[k]);
            check($sformatf("set[%0d]", k), set_v[k], es);
            check($sformatf("overflow[%0d]", k), of_v[k], eo);
            check($sformatf("eq[%0d]", k), eq_v[k], ee);
`ifdef SLT_MINMAX_EN
            check($sformatf("min[%0d]", k), mn_v[k], es ? xv : yv);
            check($sformatf("max[%0d]", k), mx_v[k], es ? yv : xv);
`endif
        end

        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = $urandom; y = $urandom;
            @(posedge clk); #1;
            check("stall_valid", ov_v, 3'b111);
            check("stall_ready", ir_v, 3'b000);
            check("stall_set", set_v, {3{es}});
            check("stall_ovf", of_v, {3{eo}});
            check("stall_eq", eq_v, {3{ee}});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", ov_v, 3'b000);
        check("back_idle", ir_v, 3'b111);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int           mode;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ir_v, 3'b111);
        check("rst_valid", ov_v, 3'b000);
        check("rst_set", set_v, 3'b000);
        check("rst_ovf", of_v, 3'b000);
        check("rst_eq", eq_v, 3'b000);
        rst_n = 1'b1;

        run_op(32'd1, 32'd7, 1'b1);
        run_op(32'h8000_0000, 32'd1, 1'b1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd1, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h0000_1234, 32'h0000_1234, 1'b1);
        run_op(32'h0000_1234, 32'h0000_1234, 1'b0);

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 3);
            rx = $urandom;
            ry = $urandom;
            if (mode == 1) ry = rx;
            if (mode == 2) begin
                rx = {1'($urandom_range(0, 1)), {(W-1){1'($urandom_range(0, 1))}}};
                ry = {~rx[W-1], ry[W-2:0]};
            end
            if (mode == 3) ry = rx + W'($urandom_range(0, 2)) - W'(1);
            run_op(rx, ry, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        x = 32'd3; y = 32'd9; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", ov_v, 3'b000);
        check("arst_ready", ir_v, 3'b111);
        check("arst_set", set_v, 3'b000);
        check("arst_ovf", of_v, 3'b000);
        check("arst_eq", eq_v, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_valid", ov_v, 3'b000);
        run_op(32'd5, 32'd3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
